// File: rtl/storage_loader.sv
`default_nettype none
// ============================================================================
// Module   : storage_loader
// Brief    : Parses a 16-bit valid/ready word stream into code, input/label
//            row and run-control packets that drive data_path storage writes.
// Revision : 1.0
// ============================================================================
module storage_loader #(
  parameter int WORD_WIDTH  = 16,
  parameter int ROW_WORDS   = 3,
  parameter int CODE_WIDTH  = 12,
  parameter int INDEX_WIDTH = 32,
  parameter int COUNT_WIDTH = 14
) (
  input  logic                            clk_clk,
  input  logic                            reset_reset,
  input  logic [WORD_WIDTH-1:0]           in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [INDEX_WIDTH-1:0]          code_write_line,
  output logic [CODE_WIDTH-1:0]           code_write_data,
  output logic                            code_is_write,
  output logic [INDEX_WIDTH-1:0]          mat_write_layer_index,
  output logic [INDEX_WIDTH-1:0]          mat_write_row_index,
  output logic [WORD_WIDTH*ROW_WORDS-1:0] mat_write_data,
  output logic                            input_is_write,
  output logic                            label_is_write,
  output logic                            matrix_locator_reset,
  output logic                            run_enable,
  output logic                            busy
);

  localparam int c_ROW_WIDTH = WORD_WIDTH * ROW_WORDS;
  localparam int c_WCW       = (ROW_WORDS > 1) ? $clog2(ROW_WORDS) : 1;
  localparam logic [c_WCW-1:0] c_LAST_WORD = c_WCW'(ROW_WORDS - 1);

  localparam logic [1:0] c_TGT_CODE  = 2'b00;
  localparam logic [1:0] c_TGT_INPUT = 2'b01;
  localparam logic [1:0] c_TGT_LABEL = 2'b10;
  localparam logic [1:0] c_TGT_CMD   = 2'b11;

  typedef enum logic [2:0] {
    HDR       = 3'd0,
    CODE_DATA = 3'd1,
    LAYER     = 3'd2,
    ROW_DATA  = 3'd3,
    LOC_RST   = 3'd4
  } state_t;

  state_t                   r_state, w_next;
  logic [1:0]               r_target;
  logic [COUNT_WIDTH-1:0]   r_count;
  logic [INDEX_WIDTH-1:0]   r_line;
  logic [INDEX_WIDTH-1:0]   r_row;
  logic [c_WCW-1:0]         r_word_cnt;
  logic [c_ROW_WIDTH-1:0]   r_asm;

  logic                     w_accept;
  logic [1:0]               w_hdr_target;
  logic [COUNT_WIDTH-1:0]   w_hdr_count;
  logic [INDEX_WIDTH-1:0]   w_count_ext;
  logic                     w_code_done;
  logic                     w_row_last_word;
  logic                     w_row_done;
  logic [c_ROW_WIDTH-1:0]   w_asm_next;

  assign in_ready             = (r_state != LOC_RST);
  assign matrix_locator_reset = (r_state == LOC_RST);
  assign busy                 = (r_state != HDR);

  assign w_accept        = in_valid & in_ready;
  assign w_hdr_target    = in_data[WORD_WIDTH-1 -: 2];
  assign w_hdr_count     = in_data[COUNT_WIDTH-1:0];
  assign w_count_ext     = {{(INDEX_WIDTH-COUNT_WIDTH){1'b0}}, r_count};
  assign w_code_done     = (r_line + INDEX_WIDTH'(1)) == w_count_ext;
  assign w_row_last_word = (r_word_cnt == c_LAST_WORD);
  assign w_row_done      = (r_row + INDEX_WIDTH'(1)) == w_count_ext;

  // Word k of a row lands in the k-th slot from the top of the row.
  always_comb begin
    w_asm_next = r_asm;
    for (int k = 0; k < ROW_WORDS; k++) begin
      if (r_word_cnt == c_WCW'(k)) begin
        w_asm_next[(ROW_WORDS-1-k)*WORD_WIDTH +: WORD_WIDTH] = in_data;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      HDR: begin
        if (w_accept) begin
          case (w_hdr_target)
            c_TGT_CODE:  w_next = (w_hdr_count != '0) ? CODE_DATA : HDR;
            c_TGT_INPUT,
            c_TGT_LABEL: w_next = LAYER;
            default:     w_next = in_data[0] ? HDR : LOC_RST;
          endcase
        end
      end
      CODE_DATA: if (w_accept && w_code_done) w_next = HDR;
      LAYER:     if (w_accept) w_next = (r_count == '0) ? HDR : ROW_DATA;
      ROW_DATA:  if (w_accept && w_row_last_word && w_row_done) w_next = HDR;
      LOC_RST:   w_next = HDR;
      default:   w_next = HDR;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_state <= HDR;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_target              <= '0;
      r_count               <= '0;
      r_line                <= '0;
      r_row                 <= '0;
      r_word_cnt            <= '0;
      r_asm                 <= '0;
      code_write_line       <= '0;
      code_write_data       <= '0;
      code_is_write         <= 1'b0;
      mat_write_layer_index <= '0;
      mat_write_row_index   <= '0;
      mat_write_data        <= '0;
      input_is_write        <= 1'b0;
      label_is_write        <= 1'b0;
      run_enable            <= 1'b0;
    end else begin
      code_is_write  <= 1'b0;
      input_is_write <= 1'b0;
      label_is_write <= 1'b0;
      case (r_state)
        HDR: begin
          if (w_accept) begin
            r_target <= w_hdr_target;
            r_count  <= w_hdr_count;
            r_line   <= '0;
            if (w_hdr_target == c_TGT_CMD && in_data[0]) begin
              run_enable <= 1'b0;
            end
          end
        end
        CODE_DATA: begin
          if (w_accept) begin
            code_write_data <= in_data[CODE_WIDTH-1:0];
            code_write_line <= r_line;
            code_is_write   <= 1'b1;
            r_line          <= r_line + INDEX_WIDTH'(1);
          end
        end
        LAYER: begin
          if (w_accept) begin
            mat_write_layer_index <= {{(INDEX_WIDTH-WORD_WIDTH){1'b0}}, in_data};
            r_row                 <= '0;
            r_word_cnt            <= '0;
          end
        end
        ROW_DATA: begin
          if (w_accept) begin
            if (w_row_last_word) begin
              mat_write_data      <= w_asm_next;
              mat_write_row_index <= r_row;
              input_is_write      <= (r_target == c_TGT_INPUT);
              label_is_write      <= (r_target == c_TGT_LABEL);
              r_row               <= r_row + INDEX_WIDTH'(1);
              r_word_cnt          <= '0;
              r_asm               <= '0;
            end else begin
              r_word_cnt <= r_word_cnt + c_WCW'(1);
              r_asm      <= w_asm_next;
            end
          end
        end
        LOC_RST: begin
          run_enable <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
